// File: rtl/timestamp_readout.sv
// Serializes latched count/phase captures from two counter channels into
// 14-byte packets on a valid/ready byte stream, then handshakes the latch reset.
module timestamp_readout #(
  parameter logic [7:0] pHDR1 = 8'hA1,
  parameter logic [7:0] pHDR2 = 8'hA2,
  parameter int         pSYNC = 2        // must be >= 2
) (
  input  logic        globalClock,
  input  logic        iReset,
  input  logic        iRdy1,
  input  logic        iRdy2,
  input  logic [31:0] i1Lo,
  input  logic [31:0] i1Hi,
  input  logic [31:0] i1Phase,
  input  logic [31:0] i2Lo,
  input  logic [31:0] i2Hi,
  input  logic [31:0] i2Phase,
  output logic        oResetLatch1,
  output logic        oResetLatch2,
  output logic [7:0]  oData,
  output logic        oValid,
  input  logic        iReady,
  output logic        oBusy,
  output logic [15:0] oPktCount
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, ACK} state_t;

  state_t      state;
  logic [pSYNC-1:0] sync1, sync2;
  logic        rdy1_s, rdy2_s;
  logic        sel2;       // channel in service: 0 = ch1, 1 = ch2
  logic        last2;      // last channel served was ch2
  logic        pick2;
  logic [95:0] shadow;     // {Phase, Hi, Lo}
  logic [3:0]  idx;
  logic [3:0]  nidx;
  logic [7:0]  csum;
  logic [7:0]  next_byte;
  logic [6:0]  bit_off;
  logic [95:0] shifted;
  logic [15:0] pkt_cnt;
  logic        xfer;
  logic        sel_rdy;

  always_ff @(posedge globalClock or posedge iReset) begin
    if (iReset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sync1[pSYNC-2:0], iRdy1};
      sync2 <= {sync2[pSYNC-2:0], iRdy2};
    end
  end

  assign rdy1_s    = sync1[pSYNC-1];
  assign rdy2_s    = sync2[pSYNC-1];
  assign xfer      = oValid & iReady;
  assign sel_rdy   = sel2 ? rdy2_s : rdy1_s;
  assign oPktCount = pkt_cnt;

  // On a tie, serve whichever channel was not served last.
  always_comb begin
    pick2 = rdy2_s;
    if (rdy1_s && rdy2_s) pick2 = ~last2;
  end

  // Byte shown after the current one is accepted; byte 13 folds in the
  // outgoing byte 12 since csum has not yet absorbed it.
  assign nidx    = idx + 4'd1;
  assign bit_off = {nidx - 4'd1, 3'b000};
  assign shifted = shadow >> bit_off;

  always_comb begin
    next_byte = shifted[7:0];
    if (nidx == 4'd13) next_byte = csum ^ oData;
  end

  always_ff @(posedge globalClock or posedge iReset) begin
    if (iReset) begin
      state        <= IDLE;
      oData        <= 8'h00;
      oValid       <= 1'b0;
      oResetLatch1 <= 1'b0;
      oResetLatch2 <= 1'b0;
      oBusy        <= 1'b0;
      pkt_cnt      <= 16'h0000;
      sel2         <= 1'b0;
      last2        <= 1'b1;
      shadow       <= '0;
      idx          <= 4'd0;
      csum         <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (rdy1_s || rdy2_s) begin
            sel2  <= pick2;
            last2 <= pick2;
            oBusy <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          shadow <= sel2 ? {i2Phase, i2Hi, i2Lo} : {i1Phase, i1Hi, i1Lo};
          idx    <= 4'd0;
          csum   <= 8'h00;
          oData  <= sel2 ? pHDR2 : pHDR1;
          oValid <= 1'b1;
          state  <= SEND;
        end
        SEND: begin
          if (xfer) begin
            csum <= csum ^ oData;
            if (idx == 4'd13) begin
              oValid  <= 1'b0;
              oData   <= 8'h00;
              pkt_cnt <= pkt_cnt + 16'd1;
              if (sel2) oResetLatch2 <= 1'b1;
              else      oResetLatch1 <= 1'b1;
              state   <= ACK;
            end else begin
              idx   <= nidx;
              oData <= next_byte;
            end
          end
        end
        ACK: begin
          // Hold the reset request until the channel is seen disarmed.
          if (!sel_rdy) begin
            oResetLatch1 <= 1'b0;
            oResetLatch2 <= 1'b0;
            oBusy        <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
